debugger_uart: RTL and testbench

//  Periodic UART debug streamer with an optional command receiver. Every DIVIDER_TICKS

---
 rtl/debugger_uart.sv | 209 ++++++++++++++++++++
 tb/tb_debugger_uart.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/debugger_uart.sv
// rtl/debugger_uart.sv - periodic UART dumper of data_in, MSB byte first, 8N1
// Optional command receiver built when DEBUGGER_CMD_RX_EN is defined.
`timescale 1ns/1ps
module debugger_uart #(
  parameter int DATA_WIDTH         = 32,
  parameter int DIVIDER_TICKS      = 1000,
  parameter int UART_TICKS_PER_BIT = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  debug_uart_rx_in,
  output logic [7:0]            debug_command,
  output logic                  debug_command_pulse,
  output logic                  debug_command_busy,
  output logic                  tx_out
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DW     = $clog2(DIVIDER_TICKS);
  localparam int TW     = $clog2(UART_TICKS_PER_BIT);
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER_TICKS - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(UART_TICKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  logic [DW-1:0] div_cnt;
  logic          trigger;

  assign trigger = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)       div_cnt <= '0;
    else if (trigger) div_cnt <= '0;
    else              div_cnt <= div_cnt + 1'b1;
  end

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_t;

  tx_state_t             tx_state, tx_state_n;
  logic [TW-1:0]         tx_tick, tx_tick_n;
  logic [3:0]            tx_bit, tx_bit_n;
  logic [IW-1:0]         tx_idx, tx_idx_n;
  logic [DATA_WIDTH-1:0] snapshot;
  logic [7:0]            tx_byte;
  logic                  tx_d;

  // tx_bit counts frame positions: 0 start, 1..8 data LSB first, 9 stop
  always_comb begin
    tx_state_n = tx_state;
    tx_tick_n  = tx_tick;
    tx_bit_n   = tx_bit;
    tx_idx_n   = tx_idx;
    case (tx_state)
      TX_IDLE: if (trigger) tx_state_n = TX_LOAD;
      TX_LOAD: begin
        tx_state_n = TX_SEND;
        tx_tick_n  = '0;
        tx_bit_n   = '0;
        tx_idx_n   = '0;
      end
      TX_SEND: begin
        if (tx_tick == BIT_LAST) begin
          tx_tick_n = '0;
          if (tx_bit == 4'd9) begin
            tx_bit_n = '0;
            if (tx_idx == IDX_LAST) tx_state_n = TX_IDLE;
            else                    tx_idx_n   = tx_idx + 1'b1;
          end else begin
            tx_bit_n = tx_bit + 4'd1;
          end
        end else begin
          tx_tick_n = tx_tick + 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Line level is computed from the next position so tx_out can stay registered
  always_comb begin
    tx_byte = snapshot[7:0];
    for (int i = 0; i < NBYTES; i++) begin
      if (tx_idx_n == IW'(i)) tx_byte = snapshot[DATA_WIDTH-1-8*i -: 8];
    end
    tx_d = 1'b1;
    if (tx_state_n == TX_SEND) begin
      if (tx_bit_n == 4'd0)       tx_d = 1'b0;
      else if (tx_bit_n <= 4'd8)  tx_d = tx_byte[3'(tx_bit_n - 4'd1)];
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_idx   <= '0;
      snapshot <= '0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tick  <= tx_tick_n;
      tx_bit   <= tx_bit_n;
      tx_idx   <= tx_idx_n;
      tx_out   <= tx_d;
      if (tx_state == TX_LOAD) snapshot <= data_in;
    end
  end

`ifdef DEBUGGER_CMD_RX_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  localparam logic [TW-1:0] HALF_LAST = TW'(UART_TICKS_PER_BIT / 2 - 1);

  rx_state_t     rx_state, rx_state_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic [TW-1:0] rx_tick, rx_tick_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n, cmd_n;
  logic          pulse_n;

  always_comb begin
    rx_state_n = rx_state;
    rx_tick_n  = rx_tick;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    cmd_n      = debug_command;
    pulse_n    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_n = RX_START;
          rx_tick_n  = '0;
        end
      end
      RX_START: begin
        if (rx_tick == HALF_LAST) begin
          rx_tick_n = '0;
          rx_bit_n  = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_tick_n = rx_tick + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_tick == BIT_LAST) begin
          rx_tick_n  = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_tick_n = rx_tick + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_tick == BIT_LAST) begin
          rx_tick_n = '0;
          if (rx_sync) begin
            cmd_n      = rx_shift;
            pulse_n    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_WAIT;
          end
        end else begin
          rx_tick_n = rx_tick + 1'b1;
        end
      end
      RX_WAIT: if (rx_sync) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_meta             <= 1'b1;
      rx_sync             <= 1'b1;
      rx_prev             <= 1'b1;
      rx_state            <= RX_IDLE;
      rx_tick             <= '0;
      rx_bit              <= '0;
      rx_shift            <= '0;
      debug_command       <= '0;
      debug_command_pulse <= 1'b0;
    end else begin
      rx_meta             <= debug_uart_rx_in;
      rx_sync             <= rx_meta;
      rx_prev             <= rx_sync;
      rx_state            <= rx_state_n;
      rx_tick             <= rx_tick_n;
      rx_bit              <= rx_bit_n;
      rx_shift            <= rx_shift_n;
      debug_command       <= cmd_n;
      debug_command_pulse <= pulse_n;
    end
  end

  assign debug_command_busy = (rx_state == RX_START) || (rx_state == RX_DATA) ||
                              (rx_state == RX_STOP);
`else
  logic unused_rx;
  assign unused_rx           = debug_uart_rx_in;
  assign debug_command       = 8'h00;
  assign debug_command_pulse = 1'b0;
  assign debug_command_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_debugger_uart.sv
// tb/tb_debugger_uart.sv - scoreboard bench for debugger_uart (TX dumps, RX commands, reset)
`timescale 1ns/1ps
module tb_debugger_uart;

`ifdef DEBUGGER_CMD_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk, reset, rx;
  logic [15:0] data_in;
  logic [7:0]  cmd, cmd50;
  logic        pulse, busy, tx, pulse50, busy50, tx50;

  debugger_uart #(.DATA_WIDTH(16), .DIVIDER_TICKS(1000), .UART_TICKS_PER_BIT(4)) u_dut (
    .clk_in(clk), .reset(reset), .data_in(data_in), .debug_uart_rx_in(rx),
    .debug_command(cmd), .debug_command_pulse(pulse), .debug_command_busy(busy), .tx_out(tx));

  debugger_uart #(.DATA_WIDTH(16), .DIVIDER_TICKS(50), .UART_TICKS_PER_BIT(4)) u_dut50 (
    .clk_in(clk), .reset(reset), .data_in(data_in), .debug_uart_rx_in(1'b1),
    .debug_command(cmd50), .debug_command_pulse(pulse50), .debug_command_busy(busy50),
    .tx_out(tx50));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } tx_exp_t;

  tx_exp_t    tx_q[$];
  int         q50[$];
  logic [7:0] rx_q[$];
  logic       en50;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b, input int c);
    tx_exp_t e;
    e.data = b;
    e.cyc  = c;
    tx_q.push_back(e);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // TX decoder: samples each bit mid-way and checks the byte and its start cycle
  logic       tx_prev, mon_busy, start_lvl;
  int         mon_t, mon_start;
  logic [7:0] mon_byte;
  tx_exp_t    mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      mon_busy = 1'b0;
      tx_prev  = 1'b1;
    end else begin
      if (!mon_busy) begin
        if (tx_prev && !tx) begin
          mon_busy  = 1'b1;
          mon_t     = 0;
          mon_start = cyc;
        end
      end else begin
        mon_t++;
        if (mon_t == 2) start_lvl = tx;
        else if (mon_t >= 6 && mon_t <= 34 && (mon_t - 2) % 4 == 0) mon_byte[(mon_t - 6) / 4] = tx;
        else if (mon_t == 38) begin
          mon_busy = 1'b0;
          if (tx_q.size() == 0) chk("tx_unexpected_frame", mon_start, 0);
          else begin
            mon_e = tx_q.pop_front();
            chk("tx_byte", mon_byte, mon_e.data);
            chk("tx_start_cycle", mon_start, mon_e.cyc);
            chk("tx_start_bit", start_lvl, 0);
            chk("tx_stop_bit", tx, 1);
          end
        end
      end
      tx_prev = tx;
    end
  end

  logic prev50;
  int   hold50;

  always @(negedge clk) begin
    if (!reset || !en50) begin
      hold50 = 0;
      prev50 = 1'b1;
    end else begin
      if (hold50 > 0) hold50--;
      else if (prev50 && !tx50) begin
        hold50 = 39;
        if (q50.size() == 0) chk("tx50_unexpected_frame", cyc, 0);
        else                 chk("tx50_frame_cycle", cyc, q50.pop_front());
      end
      prev50 = tx50;
    end
  end

  always @(negedge clk) begin
    if (reset && pulse) begin
      if (rx_q.size() == 0) chk("rx_unexpected_pulse", pulse, 0);
      else                  chk("rx_cmd_on_pulse", cmd, rx_q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 3) chk("rx_busy_mid_frame", busy, RX_EN);
      repeat (4) @(negedge clk);
    end
    rx = stop;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    rx      = 1'b1;
    data_in = 16'hA55A;
    en50    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx_out", tx, 1);
    chk("reset_cmd", cmd, 0);
    chk("reset_pulse", pulse, 0);
    chk("reset_busy", busy, 0);

    push_tx(8'hA5, 1001);
    push_tx(8'h5A, 1041);
    q50 = '{51, 91, 151, 191, 251, 291};
    reset = 1'b1;

    wait_cyc(320);
    en50 = 1'b0;

    wait_cyc(1010);
    data_in = 16'h1234;
    push_tx(8'h12, 2001);
    push_tx(8'h34, 2041);

    wait_cyc(1100);
    if (RX_EN) rx_q.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("rx_cmd_3c", cmd, RX_EN ? 8'h3C : 8'h00);
    chk("rx_busy_idle", busy, 0);

    rx_frame(8'hA7, 1'b0);
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("rx_cmd_after_framing_err", cmd, RX_EN ? 8'h3C : 8'h00);
    chk("rx_busy_after_framing_err", busy, 0);

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("rx_busy_during_glitch", busy, RX_EN);
    repeat (8) @(negedge clk);
    chk("rx_busy_after_glitch", busy, 0);
    chk("rx_cmd_after_glitch", cmd, RX_EN ? 8'h3C : 8'h00);

    if (RX_EN) rx_q.push_back(8'h81);
    rx_frame(8'h81, 1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("rx_cmd_81_rearm", cmd, RX_EN ? 8'h81 : 8'h00);

    wait_cyc(2010);
    if (RX_EN) rx_q.push_back(8'h5E);
    rx_frame(8'h5E, 1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("rx_cmd_5e_during_tx", cmd, RX_EN ? 8'h5E : 8'h00);

    wait_cyc(3014);
    chk("tx_low_before_reset", tx, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_tx_out", tx, 1);
    chk("async_reset_cmd", cmd, 0);
    chk("async_reset_pulse", pulse, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_tx50", tx50, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push_tx(8'h12, 1001);
    push_tx(8'h34, 1041);

    wait_cyc(1100);
    chk("tx_queue_drained", tx_q.size(), 0);
    chk("tx50_queue_drained", q50.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    chk("dut50_cmd_quiet", cmd50, 0);
    chk("dut50_busy_quiet", busy50, 0);
    chk("dut50_pulse_quiet", pulse50, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
